// File: rtl/adc_avg_seq.sv
// Averaging sequencer: triggers 2^N_LOG2 conversions, accumulates the results and publishes the mean.
// Optional feature macro ADC_AVG_MINMAX_EN adds per-run min_o/max_o outputs.
module adc_avg_seq #(
  parameter int unsigned N_LOG2    = 3,
  parameter int unsigned DW        = 12,
  parameter int unsigned TO_CYCLES = 4096
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          go_i,
  output logic          conv_start_o,
  input  logic [DW-1:0] conv_data_i,
  input  logic          conv_done_i,
  output logic [DW-1:0] avg_o,
  output logic          avg_valid_o,
  output logic          busy_o,
  output logic          err_o
`ifdef ADC_AVG_MINMAX_EN
  ,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] max_o
`endif
);

  localparam int unsigned AW = DW + N_LOG2;
  localparam int unsigned CW = (N_LOG2 == 0) ? 1 : N_LOG2;
  localparam int unsigned TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << N_LOG2) - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [DW-1:0] sample_q, sample_d;
  logic          done_q;
  logic          done_rise;
  logic [DW-1:0] avg_d;
  logic          start_d, valid_d, busy_d, err_d;
`ifdef ADC_AVG_MINMAX_EN
  logic [DW-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [DW-1:0] min_d, max_d;
`endif

  // Only a fresh 0->1 transition counts, so a level-style done flag is taken once.
  assign done_rise = conv_done_i & ~done_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    sample_d = sample_q;
    avg_d    = avg_o;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef ADC_AVG_MINMAX_EN
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    min_d     = min_o;
    max_d     = max_o;
`endif
    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_START;
`ifdef ADC_AVG_MINMAX_EN
          run_min_d = '1;
          run_max_d = '0;
`endif
        end
      end
      S_START: begin
        to_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          sample_d = conv_data_i;
          state_d  = S_ACC;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_ACC: begin
        acc_d = acc_q + AW'(sample_q);
`ifdef ADC_AVG_MINMAX_EN
        if (sample_q < run_min_q) run_min_d = sample_q;
        if (sample_q > run_max_q) run_max_d = sample_q;
`endif
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_START;
        end
      end
      S_DONE: begin
        avg_d   = DW'(acc_q >> N_LOG2);
        valid_d = 1'b1;
        state_d = S_IDLE;
`ifdef ADC_AVG_MINMAX_EN
        min_d = run_min_q;
        max_d = run_max_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      sample_q     <= '0;
      done_q       <= 1'b0;
      conv_start_o <= 1'b0;
      avg_o        <= '0;
      avg_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      run_min_q <= '1;
      run_max_q <= '0;
      min_o     <= '0;
      max_o     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      sample_q     <= sample_d;
      done_q       <= conv_done_i;
      conv_start_o <= start_d;
      avg_o        <= avg_d;
      avg_valid_o  <= valid_d;
      busy_o       <= busy_d;
      err_o        <= err_d;
`ifdef ADC_AVG_MINMAX_EN
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      min_o     <= min_d;
      max_o     <= max_d;
`endif
    end
  end

endmodule
